// File: rtl/rowop_pkg.sv
// rowop_pkg: shared types and constants for the row-operation sequencer.
// The optional divide-by-zero check is enabled with ROWOP_DIV0_CHECK_EN.
package rowop_pkg;

  localparam int NUM_PROGS  = 4;
  localparam int PROG_DEPTH = 16;
  localparam int DATA_W     = 8;
  localparam int PROG_W     = $clog2(NUM_PROGS);
  localparam int PC_W       = $clog2(PROG_DEPTH);

  typedef enum logic [2:0] {
    K_END    = 3'd0,
    K_LDX    = 3'd1,
    K_DIV    = 3'd2,
    K_MSUB_A = 3'd3,
    K_MSUB_B = 3'd4,
    K_RSVD5  = 3'd5,
    K_RSVD6  = 3'd6,
    K_RSVD7  = 3'd7
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dst;
  } uop_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_INIT   = 3'd1;
  localparam state_t S_FETCH  = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_ANSWER = 3'd4;
  localparam state_t S_CHECK  = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam logic [2:0] REG_EXTRA = 3'd0;
  localparam logic [2:0] REG1      = 3'd1;
  localparam logic [2:0] REG2      = 3'd2;
  localparam logic [2:0] REG3      = 3'd3;
  localparam logic [2:0] REG4      = 3'd4;
  localparam logic [2:0] REG5      = 3'd5;
  localparam logic [2:0] REG6      = 3'd6;
  localparam logic [2:0] SOL_REG0  = REG3;
  localparam logic [2:0] SOL_REG1  = REG6;

  function automatic uop_t mk_uop(kind_e k, logic [2:0] a, logic [2:0] b, logic [2:0] d);
    mk_uop = '{kind: k, src_a: a, src_b: b, dst: d};
  endfunction

  // reg1..reg6 map to ld_vec bits 0..5; any other index loads nothing
  function automatic logic [5:0] dst_onehot(logic [2:0] d);
    dst_onehot = '0;
    if (d >= REG1 && d <= REG6) dst_onehot = 6'b000001 << (d - REG1);
  endfunction

endpackage

// File: rtl/rowop_prog_rom.sv
// rowop_prog_rom: NUM_PROGS x PROG_DEPTH micro-op ROM with a registered output.
module rowop_prog_rom
  import rowop_pkg::*;
(
  input  logic              clk_i,
  input  logic [PROG_W-1:0] prog_i,
  input  logic [PC_W-1:0]   pc_i,
  output uop_t              uop_o
);

  logic [PROG_W+PC_W-1:0] addr;
  uop_t                   rom_d;

  assign addr = {prog_i, pc_i};

  // Program table; unlisted slots read as END
  always_comb begin
    rom_d = mk_uop(K_END, REG_EXTRA, REG_EXTRA, REG_EXTRA);
    case (addr)
      // program 0: full two-equation reduction, fills all 16 slots
      6'h00: rom_d = mk_uop(K_LDX,    REG1, REG_EXTRA, REG_EXTRA);
      6'h01: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG1, REG1);
      6'h02: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG2, REG2);
      6'h03: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG3, REG3);
      6'h04: rom_d = mk_uop(K_LDX,    REG4, REG_EXTRA, REG_EXTRA);
      6'h05: rom_d = mk_uop(K_MSUB_A, REG1, REG4, REG4);
      6'h06: rom_d = mk_uop(K_MSUB_A, REG2, REG5, REG5);
      6'h07: rom_d = mk_uop(K_MSUB_A, REG3, REG6, REG6);
      6'h08: rom_d = mk_uop(K_LDX,    REG5, REG_EXTRA, REG_EXTRA);
      6'h09: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG4, REG4);
      6'h0A: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG5, REG5);
      6'h0B: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG6, REG6);
      6'h0C: rom_d = mk_uop(K_LDX,    REG2, REG_EXTRA, REG_EXTRA);
      6'h0D: rom_d = mk_uop(K_MSUB_B, REG1, REG4, REG1);
      6'h0E: rom_d = mk_uop(K_MSUB_B, REG2, REG5, REG2);
      6'h0F: rom_d = mk_uop(K_MSUB_B, REG3, REG6, REG3);
      // program 1: divide reg1 by reg4
      6'h10: rom_d = mk_uop(K_LDX,    REG4, REG_EXTRA, REG_EXTRA);
      6'h11: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG1, REG1);
      // program 2: scale both solution registers by reg1
      6'h20: rom_d = mk_uop(K_LDX,    REG1, REG_EXTRA, REG_EXTRA);
      6'h21: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG3, REG3);
      6'h22: rom_d = mk_uop(K_DIV,    REG_EXTRA, REG6, REG6);
      // program 3: one reserved-kind slot, then END
      6'h30: rom_d = mk_uop(K_RSVD5,  REG1, REG2, REG3);
      default: ;
    endcase
  end

  // Registered read
  always_ff @(posedge clk_i) begin
    uop_o <= rom_d;
  end

endmodule

// File: rtl/rowop_sequencer.sv
// rowop_sequencer: ROM-programmed row-reduction controller with answer check.
// Define ROWOP_DIV0_CHECK_EN to abort on a DIV whose divisor (regExtra) is 0.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | preset datapath registers
// FETCH  | registered micro-op available, decide END/EXEC
// EXEC   | drive decoded controls for one cycle, advance pc
// ANSWER | collect two Go answers
// CHECK  | compare reg3 then reg6 against answers
// DONE   | report done/correct, wait for start
module rowop_sequencer
  import rowop_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PROG_W-1:0] eq_sel_i,
  input  logic              go_i,
  input  logic [DATA_W-1:0] answer_i,
  input  logic [DATA_W-1:0] sol_data_i,
  output logic              initalize_o,
  output logic              ld_extra_o,
  output logic [2:0]        select_extra_o,
  output logic [5:0]        ld_vec_o,
  output logic [2:0]        select_a_o,
  output logic [2:0]        select_b_o,
  output logic              mux_extra_o,
  output logic              mux_a_o,
  output logic              mux_b_o,
  output logic [1:0]        alu_mini_o,
  output logic [1:0]        alu_grand_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              correct_o,
  output logic              error_o
);

  state_t                 state_q, state_d;
  logic [PROG_W-1:0]      prog_q, prog_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   idx_q, idx_d;
  logic                   chk_q, chk_d;
  logic                   mism_q, mism_d;
  logic                   err_q, err_d;
  logic                   corr_q, corr_d;
  logic [1:0][DATA_W-1:0] ans_q, ans_d;
  uop_t                   uop_q;
  logic                   div_zero;
  logic                   miss;

  // ROM is addressed with next-state prog/pc so FETCH already sees its op
  rowop_prog_rom u_rom (
    .clk_i  (clk_i),
    .prog_i (prog_d),
    .pc_i   (pc_d),
    .uop_o  (uop_q)
  );

`ifdef ROWOP_DIV0_CHECK_EN
  // In a DIV, select_a points at regExtra, so sol_data is the divisor
  assign div_zero = (uop_q.kind == K_DIV) && (sol_data_i == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign miss      = (sol_data_i != ans_q[chk_q]);
  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign correct_o = corr_q;
  // Only ever set when the divide-by-zero check is compiled in
  assign error_o   = err_q;

  // Next-state, bookkeeping and datapath control decode
  always_comb begin
    state_d        = state_q;
    prog_d         = prog_q;
    pc_d           = pc_q;
    idx_d          = idx_q;
    chk_d          = chk_q;
    mism_d         = mism_q;
    err_d          = err_q;
    corr_d         = corr_q;
    ans_d          = ans_q;
    initalize_o    = 1'b0;
    ld_extra_o     = 1'b0;
    select_extra_o = 3'd0;
    ld_vec_o       = 6'd0;
    select_a_o     = 3'd0;
    select_b_o     = 3'd0;
    mux_extra_o    = 1'b1;
    mux_a_o        = 1'b1;
    mux_b_o        = 1'b1;
    alu_mini_o     = 2'b00;
    alu_grand_o    = 2'b00;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_INIT;
          prog_d  = eq_sel_i;
          pc_d    = '0;
          idx_d   = 1'b0;
          mism_d  = 1'b0;
          err_d   = 1'b0;
          corr_d  = 1'b0;
        end
      end
      S_INIT: begin
        initalize_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        state_d = (uop_q.kind == K_END) ? S_ANSWER : S_EXEC;
      end
      S_EXEC: begin
        case (uop_q.kind)
          K_LDX: begin
            ld_extra_o     = 1'b1;
            select_extra_o = uop_q.src_a;
          end
          K_DIV: begin
            select_a_o  = REG_EXTRA;
            select_b_o  = uop_q.src_b;
            alu_grand_o = 2'b11;
            ld_vec_o    = dst_onehot(uop_q.dst);
          end
          K_MSUB_A: begin
            select_a_o  = uop_q.src_a;
            select_b_o  = uop_q.src_b;
            alu_mini_o  = 2'b10;
            mux_a_o     = 1'b0;
            alu_grand_o = 2'b01;
            ld_vec_o    = dst_onehot(uop_q.dst);
          end
          K_MSUB_B: begin
            select_a_o  = uop_q.src_a;
            select_b_o  = uop_q.src_b;
            mux_extra_o = 1'b0;
            alu_mini_o  = 2'b10;
            mux_b_o     = 1'b0;
            alu_grand_o = 2'b01;
            ld_vec_o    = dst_onehot(uop_q.dst);
          end
          default: ;
        endcase
        pc_d    = pc_q + PC_W'(1);
        state_d = (pc_q == PC_W'(PROG_DEPTH - 1)) ? S_ANSWER : S_FETCH;
        if (div_zero) begin
          ld_vec_o = 6'd0;
          err_d    = 1'b1;
          corr_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_ANSWER: begin
        if (go_i) begin
          ans_d[idx_q] = answer_i;
          idx_d        = ~idx_q;
          if (idx_q) begin
            state_d = S_CHECK;
            chk_d   = 1'b0;
            mism_d  = 1'b0;
          end
        end
      end
      S_CHECK: begin
        select_a_o = chk_q ? SOL_REG1 : SOL_REG0;
        chk_d      = 1'b1;
        mism_d     = mism_q | miss;
        if (chk_q) begin
          corr_d  = !(mism_q | miss) && !err_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      prog_q  <= '0;
      pc_q    <= '0;
      idx_q   <= 1'b0;
      chk_q   <= 1'b0;
      mism_q  <= 1'b0;
      err_q   <= 1'b0;
      corr_q  <= 1'b0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
      ans_q   <= ans_d;
    end
  end

endmodule
